// File: rtl/i2c_pkg.sv
// Shared command encodings, FSM state type and counter widths for the I2C SCL generator.
package i2c_pkg;

  localparam int CNT_W = 8;  // holds HALF_CYC-1 for HALF_CYC up to 255
  localparam int BIT_W = 4;  // holds NBITS-1 for NBITS up to 16

  typedef enum logic [1:0] {
    CMD_START  = 2'b00,
    CMD_XFER   = 2'b01,
    CMD_STOP   = 2'b10,
    CMD_RSTART = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_XFER_LO,
    ST_XFER_HI,
    ST_HOLD,
    ST_STOP,
    ST_RSTART
  } state_e;

endpackage

// File: rtl/i2c_half_timer.sv
// Half-period phase counter: counts 0..HALF_CYC-1 while run, freezes on stall,
// and flags the first, middle and terminal counted cycles.
module i2c_half_timer #(
  parameter int HALF_CYC = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  input  logic stall,
  output logic zero_p,
  output logic mid_p,
  output logic tc_p
);
  import i2c_pkg::*;

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] MID_VAL  = CNT_W'(HALF_CYC / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv;

  always_comb begin
    adv    = run && !stall;
    zero_p = adv && (cnt_q == '0);
    mid_p  = adv && (cnt_q == MID_VAL);
    tc_p   = adv && (cnt_q == LAST_VAL);
    cnt_d  = cnt_q;
    if (load || !run) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = tc_p ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator with START/XFER/STOP/RSTART sequencing.
// Optional clock stretching with timeout is enabled by defining I2C_SCL_STRETCH_EN.
//
// state      | meaning
// IDLE       | bus free, SCL released
// START      | ph0: SCL high wait; ph1: SDA falls, SCL high wait
// XFER_LO    | SCL low for bit bit_q, SDA may change on first cycle
// XFER_HI    | SCL released for bit bit_q, SDA sampled mid-phase
// HOLD       | SCL held low between commands
// STOP       | ph0: SCL low; ph1: SCL high; ph2: SDA rises, SCL high
// RSTART     | SCL low while SDA is released, then continues as START
module i2c_scl_gen #(
  parameter int HALF_CYC    = 20,
  parameter int NBITS       = 9,
  parameter int STRETCH_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       scl_in,
  output logic       scl_oe,
  output logic       sda_change,
  output logic       sda_sample,
  output logic [3:0] bit_idx,
  output logic       cmd_done,
  output logic       err
);
  import i2c_pkg::*;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);

  state_e           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             init_q;
  logic             accept, run, stall, abort;
  logic             zero_p, mid_p, tc_p;

  assign accept = cmd_valid && cmd_ready;
  assign run    = (state_q != ST_IDLE) && (state_q != ST_HOLD);

`ifdef I2C_SCL_STRETCH_EN
  localparam int SW = $clog2(STRETCH_MAX + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STRETCH_MAX - 1);

  logic [SW-1:0] stall_q, stall_d;

  // A slave holding SCL low during a released phase freezes the phase counter.
  always_comb begin
    stall   = run && !scl_oe && !scl_in;
    abort   = stall && (stall_q == STALL_LAST);
    stall_d = (stall && !abort) ? stall_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_cfg;
  assign stall      = 1'b0;
  assign abort      = 1'b0;
  assign unused_cfg = scl_in ^ (STRETCH_MAX > 0);
`endif

  i2c_half_timer #(
    .HALF_CYC(HALF_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept || abort),
    .run   (run),
    .stall (stall),
    .zero_p(zero_p),
    .mid_p (mid_p),
    .tc_p  (tc_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      err_q   <= err_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd == CMD_START) begin
            state_d = ST_START;
            ph_d    = 2'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (accept) begin
          case (cmd)
            CMD_XFER: begin
              state_d = ST_XFER_LO;
              bit_d   = '0;
            end
            CMD_STOP: begin
              state_d = ST_STOP;
              ph_d    = 2'd0;
            end
            CMD_RSTART: state_d = ST_RSTART;
            default:    err_d   = 1'b1;
          endcase
        end
      end
      ST_START: begin
        if (tc_p) begin
          if (ph_q == 2'd1) begin
            state_d = ST_HOLD;
            ph_d    = 2'd0;
            done_d  = 1'b1;
          end else begin
            ph_d = 2'd1;
          end
        end
      end
      ST_RSTART: begin
        if (tc_p) begin
          state_d = ST_START;
          ph_d    = 2'd0;
        end
      end
      ST_STOP: begin
        if (tc_p) begin
          if (ph_q == 2'd2) begin
            state_d = ST_IDLE;
            ph_d    = 2'd0;
            done_d  = 1'b1;
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
      end
      ST_XFER_LO: begin
        if (tc_p) state_d = ST_XFER_HI;
      end
      ST_XFER_HI: begin
        if (tc_p) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_XFER_LO;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Stretch timeout abandons the bus and overrides any phase completion.
    if (abort) begin
      state_d = ST_IDLE;
      ph_d    = 2'd0;
      bit_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    scl_oe     = 1'b0;
    sda_change = 1'b0;
    sda_sample = 1'b0;
    case (state_q)
      ST_HOLD: scl_oe = 1'b1;
      ST_XFER_LO: begin
        scl_oe     = 1'b1;
        sda_change = zero_p;
      end
      ST_XFER_HI: sda_sample = mid_p;
      ST_RSTART: begin
        scl_oe     = 1'b1;
        sda_change = zero_p;
      end
      ST_START: sda_change = zero_p && (ph_q == 2'd1);
      ST_STOP: begin
        scl_oe     = (ph_q == 2'd0);
        sda_change = zero_p && (ph_q != 2'd1);
      end
      default: scl_oe = 1'b0;
    endcase
  end

  assign cmd_ready = init_q && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign cmd_done  = done_q;
  assign err       = err_q;
  assign bit_idx   = bit_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: per-cycle traces compared against a
// waveform model derived from the command timing rules.
module tb_i2c_scl_gen;
  import i2c_pkg::*;

  localparam int H  = 4;
  localparam int NB = 9;
  localparam int SM = 40;

  typedef struct packed {
    logic       oe;
    logic       chg;
    logic       smp;
    logic       done;
    logic       err;
    logic       rdy;
    logic [3:0] bidx;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       force_low = 1'b0;
  logic       scl_in;
  logic       cmd_ready, scl_oe, sda_change, sda_sample, cmd_done, err;
  logic [3:0] bit_idx;

  int   checks = 0;
  int   failures = 0;
  bit   m_hold = 1'b0;
  obs_t obs_q[$];

  always #5 clk = ~clk;
  assign scl_in = !scl_oe && !force_low;

  i2c_scl_gen #(.HALF_CYC(H), .NBITS(NB), .STRETCH_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .scl_in(scl_in), .scl_oe(scl_oe), .sda_change(sda_change), .sda_sample(sda_sample),
    .bit_idx(bit_idx), .cmd_done(cmd_done), .err(err)
  );

  function automatic obs_t sample_dut();
    obs_t o;
    o = {scl_oe, sda_change, sda_sample, cmd_done, err, cmd_ready, bit_idx};
    return o;
  endfunction

  function automatic bit is_legal(input logic [1:0] c, input bit hold);
    return (c == CMD_START) ? !hold : hold;
  endfunction

  function automatic int cmd_len(input logic [1:0] c, input bit legal);
    if (!legal) return 1;
    if (c == CMD_START) return 2*H + 1;
    if (c == CMD_XFER) return 2*H*NB + 1;
    return 3*H + 1;
  endfunction

  // Expected outputs k cycles after acceptance (k = 1 .. cmd_len).
  function automatic obs_t model_at(input logic [1:0] c, input bit legal, input bit hold, input int k);
    obs_t e;
    int   len, j, p;
    e     = '0;
    len   = cmd_len(c, legal);
    e.rdy = (k == len);
    if (!legal) begin
      e.oe  = hold;
      e.err = 1'b1;
    end else if (k == len) begin
      e.done = 1'b1;
      e.oe   = (c != CMD_STOP);
    end else if (c == CMD_START) begin
      e.chg = (k == H + 1);
    end else if (c == CMD_XFER) begin
      j      = k - 1;
      p      = j % (2*H);
      e.oe   = (p < H);
      e.chg  = (p == 0);
      e.smp  = (p == H + H/2);
      e.bidx = 4'(j / (2*H));
    end else begin
      e.oe  = (k <= H);
      e.chg = (k == 1) || (k == 2*H + 1);
    end
    return e;
  endfunction

  // Present a command at the current negedge and capture len cycles after acceptance.
  task automatic issue(input logic [1:0] c, input int len);
    obs_q.delete();
    cmd_valid = 1'b1;
    cmd       = c;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 2'($urandom);
    for (int k = 1; k <= len; k++) begin
      obs_q.push_back(sample_dut());
      if (k < len) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'($urandom);
      cmd       = 2'($urandom);
      @(negedge clk);
      o = sample_dut();
      checks++;
      if (o !== obs_t'('0)) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b required=%b", i, o, obs_t'('0));
      end
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    o = sample_dut();
    checks++;
    if (o.rdy !== 1'b1 || o.oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b oe=%b required rdy=1 oe=0", o.rdy, o.oe);
    end
    m_hold = 1'b0;
  endtask

  task automatic test_start();
    obs_t e, o;
    int   l, chg_k;
    bit   lg;
    lg = is_legal(CMD_START, m_hold);
    l  = cmd_len(CMD_START, lg);
    issue(CMD_START, l);
    chg_k = 0;
    for (int k = 1; k <= l; k++) begin
      e = model_at(CMD_START, lg, m_hold, k);
      o = obs_q[k-1];
      if (o.chg === 1'b1 && chg_k == 0) chg_k = k;
      e.bidx = '0;
      o.bidx = '0;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL start k=%0d got=%b required=%b", k, o, e);
      end
    end
    checks++;
    if (chg_k != H + 1) begin
      failures++;
      $display("FAIL start_sda_change_cycle got=%0d required=%0d", chg_k, H + 1);
    end
    if (lg) m_hold = 1'b1;
  endtask

  task automatic test_xfer();
    obs_t e, o;
    int   l, n_chg, n_smp, n_done, n_fall;
    bit   lg, prev;
    lg = is_legal(CMD_XFER, m_hold);
    l  = cmd_len(CMD_XFER, lg);
    issue(CMD_XFER, l);
    n_chg = 0; n_smp = 0; n_done = 0; n_fall = 0; prev = 1'b1;
    for (int k = 1; k <= l; k++) begin
      e = model_at(CMD_XFER, lg, m_hold, k);
      o = obs_q[k-1];
      n_chg  += int'(o.chg === 1'b1);
      n_smp  += int'(o.smp === 1'b1);
      n_done += int'(o.done === 1'b1);
      n_fall += int'(prev && o.oe === 1'b0);
      prev    = (o.oe === 1'b1);
      if (k == l) begin
        e.bidx = '0;
        o.bidx = '0;
      end
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL xfer k=%0d got=%b required=%b", k, o, e);
      end
    end
    checks++;
    if (n_chg != NB || n_smp != NB || n_done != 1 || n_fall != NB) begin
      failures++;
      $display("FAIL xfer_counts got chg=%0d smp=%0d done=%0d highs=%0d required %0d/%0d/1/%0d",
               n_chg, n_smp, n_done, n_fall, NB, NB, NB);
    end
    if (lg) m_hold = 1'b1;
  endtask

  task automatic test_scl_pin();
`ifdef I2C_SCL_STRETCH_EN
    obs_t o;
    int   k, runs, run_len, hi_len, done_k, err_k;
    bit   oe_err, rdy_err, done_seen;
    // bit 3 high phase held low by the slave for 10 cycles
    cmd_valid = 1'b1; cmd = CMD_XFER;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    k = 0; runs = 0; run_len = 0; hi_len = 0; done_k = 0;
    while (done_k == 0 && k < 2*H*NB + 30) begin
      k++;
      o = sample_dut();
      if (o.oe === 1'b0) run_len++;
      else begin
        if (run_len > 0) begin
          runs++;
          if (runs == 4) hi_len = run_len;
        end
        run_len = 0;
      end
      if (o.done === 1'b1) done_k = k;
      if (k == 2*H*3 + H) force_low = 1'b1;
      if (k == 2*H*3 + H + 10) force_low = 1'b0;
      if (done_k == 0) @(negedge clk);
    end
    force_low = 1'b0;
    checks++;
    if (hi_len != H + 10) begin
      failures++;
      $display("FAIL stretch_phase_len got=%0d required=%0d", hi_len, H + 10);
    end
    checks++;
    if (done_k != 2*H*NB + 1 + 10) begin
      failures++;
      $display("FAIL stretch_done_cycle got=%0d required=%0d", done_k, 2*H*NB + 11);
    end
    m_hold = 1'b1;
    // bit 0 high phase held low until the timeout fires
    @(negedge clk);
    cmd_valid = 1'b1; cmd = CMD_XFER;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    k = 0; err_k = 0; done_seen = 1'b0; oe_err = 1'b1; rdy_err = 1'b0;
    while (err_k == 0 && k < H + SM + 10) begin
      k++;
      o = sample_dut();
      if (o.done === 1'b1) done_seen = 1'b1;
      if (o.err === 1'b1) begin
        err_k   = k;
        oe_err  = o.oe;
        rdy_err = o.rdy;
      end
      if (k == H) force_low = 1'b1;
      if (err_k == 0) @(negedge clk);
    end
    force_low = 1'b0;
    checks++;
    if (err_k != H + 1 + SM || oe_err !== 1'b0 || rdy_err !== 1'b1 || done_seen) begin
      failures++;
      $display("FAIL stretch_timeout got err_k=%0d oe=%b rdy=%b done=%b required err_k=%0d oe=0 rdy=1 done=0",
               err_k, oe_err, rdy_err, done_seen, H + 1 + SM);
    end
    @(negedge clk);
    o = sample_dut();
    checks++;
    if (o.err !== 1'b0 || o.oe !== 1'b0) begin
      failures++;
      $display("FAIL stretch_after_timeout got err=%b oe=%b required err=0 oe=0", o.err, o.oe);
    end
    m_hold = 1'b0;
`else
    obs_t       e, o;
    logic [1:0] seq[2];
    int         l;
    bit         lg;
    // scl_in pulled low throughout must not change any phase length
    seq[0]    = CMD_XFER;
    seq[1]    = CMD_STOP;
    force_low = 1'b1;
    for (int s = 0; s < 2; s++) begin
      lg = is_legal(seq[s], m_hold);
      l  = cmd_len(seq[s], lg);
      issue(seq[s], l);
      for (int k = 1; k <= l; k++) begin
        e = model_at(seq[s], lg, m_hold, k);
        o = obs_q[k-1];
        if (!(lg && seq[s] == CMD_XFER && k < l)) begin
          e.bidx = '0;
          o.bidx = '0;
        end
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL scl_ignored cmd=%0d k=%0d got=%b required=%b", seq[s], k, o, e);
        end
      end
      if (lg) m_hold = (seq[s] != CMD_STOP);
    end
    force_low = 1'b0;
`endif
  endtask

  task automatic test_illegal();
    obs_t       e, o;
    logic [1:0] seq[6];
    int         l;
    bit         lg;
    seq = '{CMD_XFER, CMD_STOP, CMD_RSTART, CMD_START, CMD_START, CMD_STOP};
    for (int s = 0; s < 6; s++) begin
      lg = is_legal(seq[s], m_hold);
      l  = cmd_len(seq[s], lg);
      issue(seq[s], l);
      for (int k = 1; k <= l; k++) begin
        e = model_at(seq[s], lg, m_hold, k);
        o = obs_q[k-1];
        e.bidx = '0;
        o.bidx = '0;
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL illegal step=%0d k=%0d got=%b required=%b", s, k, o, e);
        end
      end
      if (lg) m_hold = (seq[s] != CMD_STOP);
    end
  endtask

  task automatic test_sequence();
    obs_t       e, o;
    logic [1:0] seq[5];
    int         l, n_done, stop_chg;
    bit         lg, last_oe;
    seq = '{CMD_START, CMD_XFER, CMD_RSTART, CMD_XFER, CMD_STOP};
    n_done = 0; stop_chg = 0; last_oe = 1'b1;
    for (int s = 0; s < 5; s++) begin
      lg = is_legal(seq[s], m_hold);
      l  = cmd_len(seq[s], lg);
      issue(seq[s], l);
      for (int k = 1; k <= l; k++) begin
        e = model_at(seq[s], lg, m_hold, k);
        o = obs_q[k-1];
        n_done += int'(o.done === 1'b1);
        if (s == 4) stop_chg += int'(o.chg === 1'b1);
        last_oe = o.oe;
        if (!(lg && seq[s] == CMD_XFER && k < l)) begin
          e.bidx = '0;
          o.bidx = '0;
        end
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL sequence step=%0d k=%0d got=%b required=%b", s, k, o, e);
        end
      end
      if (lg) m_hold = (seq[s] != CMD_STOP);
    end
    checks++;
    if (n_done != 5 || stop_chg != 2 || last_oe !== 1'b0) begin
      failures++;
      $display("FAIL sequence_summary got done=%0d stop_chg=%0d oe=%b required 5/2/0", n_done, stop_chg, last_oe);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   cut, n_done;
    issue(CMD_START, 2*H + 1);
    cut = 2*H*5 + 3;
    cmd_valid = 1'b1; cmd = CMD_XFER;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k < cut; k++) @(negedge clk);
    o = sample_dut();
    checks++;
    if (o.bidx !== 4'((cut - 1) / (2*H))) begin
      failures++;
      $display("FAIL reset_mid_bit got=%0d required=%0d", o.bidx, (cut - 1) / (2*H));
    end
    rst_n = 1'b0;
    @(negedge clk);
    o = sample_dut();
    checks++;
    if (o.oe !== 1'b0 || o.done !== 1'b0 || o.rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abort got oe=%b done=%b rdy=%b required 0/0/0", o.oe, o.done, o.rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    @(negedge clk);
    o = sample_dut();
    checks++;
    if (o.rdy !== 1'b1 || o.oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release got rdy=%b oe=%b required rdy=1 oe=0", o.rdy, o.oe);
    end
    for (int k = 0; k < 2*H; k++) begin
      @(negedge clk);
      n_done += int'(cmd_done === 1'b1);
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d required=0", n_done);
    end
    m_hold = 1'b0;
  endtask

  task automatic test_random();
    obs_t       e, o;
    logic [1:0] c;
    int         l, gap;
    bit         lg;
    for (int n = 0; n < 30; n++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        o      = sample_dut();
        e      = '0;
        e.oe   = m_hold;
        e.rdy  = 1'b1;
        o.bidx = '0;
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL random_gap n=%0d got=%b required=%b", n, o, e);
        end
      end
      c  = 2'($urandom_range(0, 3));
      lg = is_legal(c, m_hold);
      l  = cmd_len(c, lg);
      issue(c, l);
      for (int k = 1; k <= l; k++) begin
        e = model_at(c, lg, m_hold, k);
        o = obs_q[k-1];
        if (!(lg && c == CMD_XFER && k < l)) begin
          e.bidx = '0;
          o.bidx = '0;
        end
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL random n=%0d cmd=%0d k=%0d got=%b required=%b", n, c, k, o, e);
        end
      end
      if (lg) m_hold = (c != CMD_STOP);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_xfer();
    test_scl_pin();
    test_illegal();
    test_sequence();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
